axi_lite_to_apb_bridge: RTL and testbench

//  Converts the 32-bit AXI4-Lite peripheral bus leaving the SoC interconnect into APB3/APB4 transfers.

---
 rtl/axi_lite_to_apb_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_axi_lite_to_apb_bridge.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_to_apb_bridge.sv
// -----------------------------------------------------------------------------
// axi_lite_to_apb_bridge
// Bridges a 32-bit AXI4-Lite slave port onto an APB3/APB4 master with
// NR_APB_SLAVES one-hot slot selects. Only one transfer is in flight at a time.
// The read and write channels are arbitrated round-robin. The slot index comes
// from addr[SEL_LSB +: $clog2(NR_APB_SLAVES)]. An index with no slot behind it
// is answered with SLVERR, and no APB cycle is run. A slot that holds PREADY low
// for TIMEOUT ACCESS cycles is aborted with SLVERR.
//
// Ports
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   aw_* / w_* / b_*                   AXI-Lite write address, data, response
//   ar_* / r_*                         AXI-Lite read address, read response
//   paddr_o, pprot_o, psel_o,          APB request (psel_o one-hot per slot)
//   penable_o, pwrite_o, pwdata_o,
//   pstrb_o
//   prdata_i, pready_i, pslverr_i      per-slot APB completion (slot k at k)
// -----------------------------------------------------------------------------
module axi_lite_to_apb_bridge #(
   parameter int NR_APB_SLAVES = 8,
   parameter int SEL_LSB       = 12,
   parameter int TIMEOUT       = 255
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [31:0]                 aw_addr_i,
   input  logic [2:0]                  aw_prot_i,
   input  logic                        aw_valid_i,
   output logic                        aw_ready_o,
   input  logic [31:0]                 w_data_i,
   input  logic [3:0]                  w_strb_i,
   input  logic                        w_valid_i,
   output logic                        w_ready_o,
   output logic [1:0]                  b_resp_o,
   output logic                        b_valid_o,
   input  logic                        b_ready_i,
   input  logic [31:0]                 ar_addr_i,
   input  logic [2:0]                  ar_prot_i,
   input  logic                        ar_valid_i,
   output logic                        ar_ready_o,
   output logic [31:0]                 r_data_o,
   output logic [1:0]                  r_resp_o,
   output logic                        r_valid_o,
   input  logic                        r_ready_i,
   output logic [31:0]                 paddr_o,
   output logic [2:0]                  pprot_o,
   output logic [NR_APB_SLAVES-1:0]    psel_o,
   output logic                        penable_o,
   output logic                        pwrite_o,
   output logic [31:0]                 pwdata_o,
   output logic [3:0]                  pstrb_o,
   input  logic [32*NR_APB_SLAVES-1:0] prdata_i,
   input  logic [NR_APB_SLAVES-1:0]    pready_i,
   input  logic [NR_APB_SLAVES-1:0]    pslverr_i
);

   localparam int          IDX_W        = (NR_APB_SLAVES > 1) ? $clog2(NR_APB_SLAVES) : 1;
   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam logic [1:0]  RESP_SLVERR  = 2'b10;
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

   state_t                     r_state;
   logic                       r_last_rd;   // channel granted most recently was read
   logic [IDX_W-1:0]           r_idx;
   logic [15:0]                r_tmo_cnt;
   logic [31:0]                r_paddr;
   logic [2:0]                 r_pprot;
   logic [NR_APB_SLAVES-1:0]   r_psel;
   logic                       r_penable;
   logic                       r_pwrite;
   logic [31:0]                r_pwdata;
   logic [3:0]                 r_pstrb;
   logic [1:0]                 r_resp;
   logic [31:0]                r_rdata;
   logic                       r_bvalid;
   logic                       r_rvalid;

   logic                       w_idle;
   logic                       w_wr_cand;
   logic                       w_grant_rd;
   logic                       w_grant_wr;
   logic [31:0]                w_acc_addr;
   logic [IDX_W-1:0]           w_acc_idx;
   logic                       w_acc_hit;
   logic [NR_APB_SLAVES-1:0]   w_acc_onehot;
   logic                       w_pready;
   logic                       w_pslverr;
   logic [31:0]                w_prdata;

   // NOTE: the ready outputs are decoded from the registered state so that
   // acceptance happens in the same cycle as the valid. They are gated with
   // rst_i so that they also go low immediately when reset is asserted.
   assign w_idle     = (r_state == ST_IDLE) && !rst_i;
   assign w_wr_cand  = aw_valid_i && w_valid_i;
   assign w_grant_rd = w_idle && ar_valid_i && (!w_wr_cand || !r_last_rd);
   assign w_grant_wr = w_idle && w_wr_cand && !w_grant_rd;
   assign w_acc_addr = w_grant_rd ? ar_addr_i : aw_addr_i;

   if (NR_APB_SLAVES > 1) begin : g_idx
      assign w_acc_idx = w_acc_addr[SEL_LSB +: IDX_W];
   end else begin : g_idx_single
      assign w_acc_idx = '0;
   end

   // An index field wider than the slot count can point past the last slot.
   assign w_acc_hit = 32'(w_acc_idx) < 32'(NR_APB_SLAVES);

   always_comb begin
      w_acc_onehot = '0;
      for (int k = 0; k < NR_APB_SLAVES; k++) begin
         if (32'(w_acc_idx) == k) w_acc_onehot[k] = 1'b1;
      end
   end

   assign w_pready  = pready_i[r_idx];
   assign w_pslverr = pslverr_i[r_idx];
   assign w_prdata  = prdata_i[{r_idx, 5'd0} +: 32];

   // NOTE: all state is assigned non-blocking so that every branch sees
   // the values from the start of the cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_last_rd <= 1'b0;         // read wins the first contention
         r_idx     <= '0;
         r_tmo_cnt <= '0;
         r_paddr   <= '0;
         r_pprot   <= '0;
         r_psel    <= '0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
         r_resp    <= RESP_OKAY;
         r_rdata   <= '0;
         r_bvalid  <= 1'b0;
         r_rvalid  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_grant_rd || w_grant_wr) begin
                  r_last_rd <= w_grant_rd;
                  r_idx     <= w_acc_idx;
                  r_paddr   <= w_acc_addr;
                  r_pprot   <= w_grant_rd ? ar_prot_i : aw_prot_i;
                  r_pwrite  <= w_grant_wr;
                  r_pwdata  <= w_grant_wr ? w_data_i : 32'h0;
                  r_pstrb   <= w_grant_wr ? w_strb_i : 4'h0;
                  if (w_acc_hit) begin
                     r_psel  <= w_acc_onehot;
                     r_state <= ST_SETUP;
                  end else begin
                     // No slot at this index: answer at once, and leave the APB side quiet.
                     r_resp   <= RESP_SLVERR;
                     r_rdata  <= '0;
                     r_bvalid <= w_grant_wr;
                     r_rvalid <= w_grant_rd;
                     r_state  <= ST_RESP;
                  end
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_tmo_cnt <= '0;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (w_pready) begin
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  r_resp    <= w_pslverr ? RESP_SLVERR : RESP_OKAY;
                  r_rdata   <= r_pwrite ? 32'h0 : w_prdata;
                  r_bvalid  <= r_pwrite;
                  r_rvalid  <= !r_pwrite;
                  r_state   <= ST_RESP;
               end else if (r_tmo_cnt == TIMEOUT_LAST) begin
                  // This is the TIMEOUT-th ACCESS cycle without PREADY, so abort the transfer.
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  r_resp    <= RESP_SLVERR;
                  r_rdata   <= '0;
                  r_bvalid  <= r_pwrite;
                  r_rvalid  <= !r_pwrite;
                  r_state   <= ST_RESP;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 16'd1;
               end
            end
            ST_RESP: begin
               if ((r_bvalid && b_ready_i) || (r_rvalid && r_ready_i)) begin
                  r_bvalid <= 1'b0;
                  r_rvalid <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign aw_ready_o = w_grant_wr;
   assign w_ready_o  = w_grant_wr;
   assign ar_ready_o = w_grant_rd;
   assign b_resp_o   = r_resp;
   assign b_valid_o  = r_bvalid;
   assign r_resp_o   = r_resp;
   assign r_data_o   = r_rdata;
   assign r_valid_o  = r_rvalid;
   assign paddr_o    = r_paddr;
   assign pprot_o    = r_pprot;
   assign psel_o     = r_psel;
   assign penable_o  = r_penable;
   assign pwrite_o   = r_pwrite;
   assign pwdata_o   = r_pwdata;
   assign pstrb_o    = r_pstrb;

endmodule

// File: tb/tb_axi_lite_to_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_to_apb_bridge
// Testbench for the bridge, configured with 6 slots. With 6 slots the 3-bit
// index field can also address slots 6 and 7, which do not exist.
// The bench keeps a transaction-level model of the transfer in flight. The
// model records the accept cycle, the slot, and the planned slave wait and
// error. From these it derives each cycle's expected APB phase and response.
// Inputs are driven 2 time units after the rising edge. Outputs are sampled
// 1 time unit later.
// -----------------------------------------------------------------------------
module tb_axi_lite_to_apb_bridge;

   localparam int NR      = 6;
   localparam int SEL_LSB = 12;
   localparam int TIMEOUT = 255;
   localparam int IDX_MSK = 7;            // $clog2(6) = 3 index bits
   localparam int NEVER   = 1_000_000;    // slave wait that never completes

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [31:0]       aw_addr_i;
   logic [2:0]        aw_prot_i;
   logic              aw_valid_i;
   logic              aw_ready_o;
   logic [31:0]       w_data_i;
   logic [3:0]        w_strb_i;
   logic              w_valid_i;
   logic              w_ready_o;
   logic [1:0]        b_resp_o;
   logic              b_valid_o;
   logic              b_ready_i;
   logic [31:0]       ar_addr_i;
   logic [2:0]        ar_prot_i;
   logic              ar_valid_i;
   logic              ar_ready_o;
   logic [31:0]       r_data_o;
   logic [1:0]        r_resp_o;
   logic              r_valid_o;
   logic              r_ready_i;
   logic [31:0]       paddr_o;
   logic [2:0]        pprot_o;
   logic [NR-1:0]     psel_o;
   logic              penable_o;
   logic              pwrite_o;
   logic [31:0]       pwdata_o;
   logic [3:0]        pstrb_o;
   logic [32*NR-1:0]  prdata_i;
   logic [NR-1:0]     pready_i;
   logic [NR-1:0]     pslverr_i;

   axi_lite_to_apb_bridge #(
      .NR_APB_SLAVES (NR),
      .SEL_LSB       (SEL_LSB),
      .TIMEOUT       (TIMEOUT)
   ) dut (
      .clk_i      (clk_i),      .rst_i      (rst_i),
      .aw_addr_i  (aw_addr_i),  .aw_prot_i  (aw_prot_i),
      .aw_valid_i (aw_valid_i), .aw_ready_o (aw_ready_o),
      .w_data_i   (w_data_i),   .w_strb_i   (w_strb_i),
      .w_valid_i  (w_valid_i),  .w_ready_o  (w_ready_o),
      .b_resp_o   (b_resp_o),   .b_valid_o  (b_valid_o),  .b_ready_i (b_ready_i),
      .ar_addr_i  (ar_addr_i),  .ar_prot_i  (ar_prot_i),
      .ar_valid_i (ar_valid_i), .ar_ready_o (ar_ready_o),
      .r_data_o   (r_data_o),   .r_resp_o   (r_resp_o),
      .r_valid_o  (r_valid_o),  .r_ready_i  (r_ready_i),
      .paddr_o    (paddr_o),    .pprot_o    (pprot_o),    .psel_o    (psel_o),
      .penable_o  (penable_o),  .pwrite_o   (pwrite_o),
      .pwdata_o   (pwdata_o),   .pstrb_o    (pstrb_o),
      .prdata_i   (prdata_i),   .pready_i   (pready_i),   .pslverr_i (pslverr_i)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of the transfer in flight ----------------
   bit          m_busy, m_rd, m_ok, m_err, m_perr, m_last_rd;
   int          m_t;          // cycles since accept (1 = first cycle after accept)
   int          m_slot, m_wait, m_alen;
   logic [31:0] m_addr, m_wdata, m_pdata, m_rdata;
   logic [2:0]  m_prot;
   logic [3:0]  m_strb;
   // slave behaviour for the next accepted transfer
   int          n_wait;
   bit          n_err;
   logic [31:0] n_data;
   // per-cycle results
   bit          g_rd, g_wr, in_resp, hs_r, hs_w;
   logic        s_arr, s_awr, s_wr, s_bv, s_rv, s_pen;
   logic [NR-1:0] s_psel;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;

   task automatic model_reset();
      m_busy    = 1'b0;
      m_last_rd = 1'b0;
      m_t       = 0;
   endtask

   // Slave side: the selected slot responds on its planned ACCESS cycle. All other slots, and every slot while idle, toggle randomly.
   task automatic drive_slaves();
      for (int k = 0; k < NR; k++) begin
         pready_i[k]         = 1'($urandom);
         pslverr_i[k]        = 1'($urandom);
         prdata_i[32*k +: 32] = $urandom;
      end
      if (m_busy && m_ok) begin
         pready_i[m_slot]          = (m_t == 2 + m_wait);
         pslverr_i[m_slot]         = m_perr;
         prdata_i[32*m_slot +: 32] = m_pdata;
      end
   endtask

   task automatic compare();
      logic          wr_cand;
      logic [NR-1:0] oh;
      wr_cand = aw_valid_i && w_valid_i;
      g_rd    = !m_busy && ar_valid_i && (!wr_cand || !m_last_rd);
      g_wr    = !m_busy && wr_cand && !g_rd;
      in_resp = m_busy && (!m_ok || m_t >= 2 + m_alen);
      check("ar_ready", s_arr, g_rd);
      check("aw_ready", s_awr, g_wr);
      check("w_ready",  s_wr,  g_wr);
      check("b_valid",  s_bv,  in_resp && !m_rd);
      check("r_valid",  s_rv,  in_resp && m_rd);
      if (m_busy && !in_resp) begin
         oh = '0;
         oh[m_slot] = 1'b1;
         check("psel",    s_psel,   oh);
         check("penable", s_pen,    m_t >= 2);
         check("paddr",   paddr_o,  m_addr);
         check("pprot",   pprot_o,  m_prot);
         check("pwrite",  pwrite_o, !m_rd);
         check("pstrb",   pstrb_o,  m_strb);
         if (!m_rd) check("pwdata", pwdata_o, m_wdata);
      end else begin
         check("psel_idle",    s_psel, '0);
         check("penable_idle", s_pen,  1'b0);
      end
      if (in_resp && m_rd) begin
         check("r_resp", s_rresp, m_err ? 2'b10 : 2'b00);
         check("r_data", s_rdata, m_rdata);
      end
      if (in_resp && !m_rd) check("b_resp", s_bresp, m_err ? 2'b10 : 2'b00);
   endtask

   task automatic advance();
      if (!m_busy) begin
         if (g_rd || g_wr) begin
            m_busy    = 1'b1;
            m_t       = 1;
            m_rd      = g_rd;
            m_last_rd = g_rd;
            m_addr    = g_rd ? ar_addr_i : aw_addr_i;
            m_prot    = g_rd ? ar_prot_i : aw_prot_i;
            m_wdata   = w_data_i;
            m_strb    = g_rd ? 4'h0 : w_strb_i;
            m_slot    = int'(m_addr >> SEL_LSB) & IDX_MSK;
            m_ok      = m_slot < NR;
            m_wait    = n_wait;
            m_perr    = n_err;
            m_pdata   = n_data;
            if (m_wait + 1 <= TIMEOUT) begin
               m_alen  = m_wait + 1;
               m_err   = m_perr;
               m_rdata = m_rd ? m_pdata : 32'h0;
            end else begin
               m_alen  = TIMEOUT;
               m_err   = 1'b1;
               m_rdata = 32'h0;
            end
            if (!m_ok) begin
               m_err   = 1'b1;
               m_rdata = 32'h0;
            end
         end
      end else if (in_resp && (m_rd ? r_ready_i : b_ready_i)) begin
         m_busy = 1'b0;
      end else begin
         m_t++;
      end
   endtask

   // One clock cycle. Called at edge+2; samples at edge+3; returns at the next edge+2.
   task automatic cycle();
      drive_slaves();
      #1;
      s_arr   = ar_ready_o;  s_awr  = aw_ready_o; s_wr    = w_ready_o;
      s_bv    = b_valid_o;   s_rv   = r_valid_o;  s_pen   = penable_o;
      s_psel  = psel_o;      s_bresp = b_resp_o;  s_rresp = r_resp_o;
      s_rdata = r_data_o;
      hs_r = ar_valid_i && s_arr;
      hs_w = aw_valid_i && s_awr && w_valid_i && s_wr;
      compare();
      advance();
      @(posedge clk_i);
      #2;
      if (ar_valid_i && s_arr) ar_valid_i = 1'b0;
      if (aw_valid_i && s_awr) aw_valid_i = 1'b0;
      if (w_valid_i  && s_wr)  w_valid_i  = 1'b0;
   endtask

   // Run until a response cycle; report cycles used, ACCESS cycles and whether any psel was seen.
   task automatic wait_resp(input int max, output int n, output int pens, output bit seen);
      n = 0; pens = 0; seen = 1'b0;
      do begin
         cycle();
         n++;
         if (s_pen) pens++;
         if (s_psel != '0) seen = 1'b1;
      end while (!(s_bv || s_rv) && n < max);
      check("resp_within_bound", s_bv || s_rv, 1'b1);
   endtask

   task automatic drain();
      int k;
      ar_valid_i = 1'b0; aw_valid_i = 1'b0; w_valid_i = 1'b0;
      b_ready_i  = 1'b1; r_ready_i  = 1'b1;
      k = 0;
      while (m_busy && k < 600) begin
         cycle();
         k++;
      end
      check("drain_idle", m_busy, 1'b0);
   endtask

   task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      aw_addr_i = a; aw_prot_i = 3'b001; w_data_i = d; w_strb_i = s;
      aw_valid_i = 1'b1; w_valid_i = 1'b1;
   endtask

   task automatic issue_read(input logic [31:0] a);
      ar_addr_i = a; ar_prot_i = 3'b010; ar_valid_i = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n, pens, got;
      bit  seen, exp_rd;
      rst_i = 1'b1;
      aw_addr_i = '0; aw_prot_i = '0; aw_valid_i = 1'b0;
      w_data_i = '0; w_strb_i = '0; w_valid_i = 1'b0;
      ar_addr_i = '0; ar_prot_i = '0; ar_valid_i = 1'b0;
      b_ready_i = 1'b1; r_ready_i = 1'b1;
      prdata_i = '0; pready_i = '0; pslverr_i = '0;
      n_wait = 0; n_err = 1'b0; n_data = '0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #2;

      // Reset state. The valids are already high, but nothing may be accepted during reset.
      issue_read(32'h0000_3000);
      issue_write(32'h1000_2004, 32'hDEAD_BEEF, 4'hF);
      #1;
      check("rst_ar_ready", ar_ready_o, 1'b0);
      check("rst_aw_ready", aw_ready_o, 1'b0);
      check("rst_psel",     psel_o,     '0);
      check("rst_penable",  penable_o,  1'b0);
      check("rst_valids",   {b_valid_o, r_valid_o}, 2'b00);
      check("rst_paddr",    paddr_o,    32'h0);
      rst_i = 1'b0;

      // Read and write contend: the read is served first (slot 3, 3 wait states), then the write.
      n_wait = 3; n_err = 1'b0; n_data = 32'h1234_5678;
      cycle();
      check("contend_read_first", hs_r, 1'b1);
      check("contend_write_held", s_awr, 1'b0);
      n_wait = 0; n_data = $urandom;
      wait_resp(20, n, pens, seen);
      check("rd_access_cycles", pens, 4);
      check("rd_data_lit", s_rdata, 32'h1234_5678);
      check("rd_resp_lit", s_rresp, 2'b00);
      cycle();
      check("wr_accept", hs_w, 1'b1);
      cycle();
      check("wr_setup_psel", s_psel, 6'h04);
      check("wr_setup_penable", s_pen, 1'b0);
      cycle();
      check("wr_access_penable", s_pen, 1'b1);
      cycle();
      check("wr_bvalid_n3", s_bv, 1'b1);
      check("wr_bresp_okay", s_bresp, 2'b00);

      // Sustained contention: the grants alternate read/write, starting with read because the last grant was a write.
      exp_rd = 1'b1; got = 0;
      for (int i = 0; i < 80 && got < 6; i++) begin
         if (!ar_valid_i) issue_read(32'h0000_1000 + 32'(got * 4));
         if (!aw_valid_i) issue_write(32'h0000_4000, $urandom, 4'h3);
         cycle();
         if (hs_r || hs_w) begin
            check("rr_order", hs_r, exp_rd);
            exp_rd = !exp_rd;
            got++;
         end
      end
      check("rr_grant_count", got, 6);
      drain();

      // Slot 5 reports PSLVERR on a write.
      n_wait = 1; n_err = 1'b1;
      issue_write(32'h0000_5000, 32'h0BAD_F00D, 4'h5);
      cycle();
      check("slverr_accept", hs_w, 1'b1);
      wait_resp(20, n, pens, seen);
      check("slverr_bresp", s_bresp, 2'b10);

      // Index 7 has no slot: SLVERR one cycle after accept, with no APB activity.
      n_err = 1'b0;
      issue_read(32'h0000_7000);
      cycle();
      wait_resp(10, n, pens, seen);
      check("decode_err_latency", n, 1);
      check("decode_err_no_psel", seen, 1'b0);
      check("decode_err_resp", s_rresp, 2'b10);
      check("decode_err_data", s_rdata, 32'h0);

      // The slot never raises PREADY: abort after TIMEOUT ACCESS cycles, then a normal read follows.
      n_wait = NEVER;
      issue_write(32'h0000_1008, 32'hCAFE_0001, 4'hF);
      cycle();
      n_wait = 0; n_data = 32'hA5A5_5A5A;
      wait_resp(400, n, pens, seen);
      check("timeout_access_cycles", pens, TIMEOUT);
      check("timeout_bresp", s_bresp, 2'b10);
      issue_read(32'h0000_0010);
      cycle();
      wait_resp(10, n, pens, seen);
      check("after_timeout_data", s_rdata, 32'hA5A5_5A5A);
      check("after_timeout_resp", s_rresp, 2'b00);

      // B held off for 10 cycles: the response stays stable and a waiting AR is not accepted.
      b_ready_i = 1'b0;
      issue_write(32'h0000_4000, 32'h1111_2222, 4'hC);
      cycle();
      wait_resp(10, n, pens, seen);
      issue_read(32'h0000_0000);
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("bhold_valid", s_bv, 1'b1);
         check("bhold_resp", s_bresp, 2'b00);
         check("bhold_no_ar", s_arr, 1'b0);
      end
      b_ready_i = 1'b1;
      cycle();
      cycle();
      check("bhold_then_read", hs_r, 1'b1);
      drain();

      // Random traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         n_wait = ($urandom_range(0, 24) == 0) ? NEVER : int'($urandom_range(0, 3));
         n_err  = ($urandom_range(0, 3) == 0);
         n_data = $urandom;
         b_ready_i = ($urandom_range(0, 3) != 0);
         r_ready_i = ($urandom_range(0, 3) != 0);
         if (!ar_valid_i && $urandom_range(0, 2) == 0) begin
            ar_valid_i = 1'b1; ar_addr_i = $urandom; ar_prot_i = 3'($urandom);
         end
         if (!aw_valid_i && $urandom_range(0, 2) == 0) begin
            aw_valid_i = 1'b1; aw_addr_i = $urandom; aw_prot_i = 3'($urandom);
         end
         if (!w_valid_i && $urandom_range(0, 2) == 0) begin
            w_valid_i = 1'b1; w_data_i = $urandom; w_strb_i = 4'($urandom);
         end
         cycle();
      end
      drain();

      // Reset during ACCESS: outputs clear at once, and the transfer is dropped without a response.
      n_wait = NEVER;
      issue_read(32'h0000_2000);
      cycle();
      cycle();
      cycle();
      cycle();
      check("pre_reset_in_access", s_pen, 1'b1);
      rst_i = 1'b1;
      #1;
      check("arst_psel",    psel_o,    '0);
      check("arst_penable", penable_o, 1'b0);
      check("arst_valids",  {b_valid_o, r_valid_o}, 2'b00);
      check("arst_ready",   {ar_ready_o, aw_ready_o, w_ready_o}, 3'b000);
      model_reset();
      repeat (2) @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      check("arst_no_response", s_rv, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
